// File: rtl/x_trigger_dual_ctrl_pkg.sv
// Shared types and default sizing for the dual-path trigger sequencer.
package x_trigger_dual_ctrl_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int HOLD_W_DEF  = 16;
    localparam int CNT_W_DEF   = 16;
    localparam int TIMEOUT_DEF = 1024;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

endpackage

// File: rtl/x_sat_cnt.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module x_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/x_trigger_dual_ctrl.sv
// Arms on request, snapshots the idle delay-line word and captures the first
// differing word, hands it off on valid/ready, then holds off and flips path.
module x_trigger_dual_ctrl
    import x_trigger_dual_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int HOLD_W  = HOLD_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_arm,
    input  logic              i_abort,
    input  logic [HOLD_W-1:0] i_holdoff,
    input  logic              i_ready,
    output logic              o_sel,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_busy,
    output logic              o_timeout,
    output logic [CNT_W-1:0]  o_count
);

    localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   baseline_q, baseline_d;
    logic [HOLD_W-1:0]   hold_len_q, hold_len_d;
    logic [HOLD_W-1:0]   hcnt_q, hcnt_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic                sel_q, sel_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                timeout_q, timeout_d;
    logic                busy_q;
    logic                count_en;

    // Abort overrides every state event, including a handshake accepted in
    // the same cycle, so it must be decoded ahead of the state case.
    always_comb begin
        state_d    = state_q;
        baseline_d = baseline_q;
        hold_len_d = hold_len_q;
        hcnt_d     = hcnt_q;
        tcnt_d     = tcnt_q;
        sel_d      = sel_q;
        data_d     = data_q;
        valid_d    = valid_q;
        timeout_d  = 1'b0;
        count_en   = 1'b0;

        if (i_abort) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_arm) begin
                        baseline_d = i_data;
                        hold_len_d = i_holdoff;
                        tcnt_d     = '0;
                        state_d    = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (i_data != baseline_q) begin
                        data_d  = i_data;
                        valid_d = 1'b1;
                        state_d = ST_CAPTURE;
                    end else if (tcnt_q == TCNT_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    if (valid_q && i_ready) begin
                        valid_d  = 1'b0;
                        sel_d    = ~sel_q;
                        count_en = 1'b1;
                        if (hold_len_q == '0) begin
                            state_d = ST_IDLE;
                        end else begin
                            // Loading len-1 here makes the total hold-off exactly len cycles.
                            hcnt_d  = hold_len_q - HOLD_W'(1);
                            state_d = ST_HOLDOFF;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (hcnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        hcnt_d = hcnt_q - HOLD_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q    <= ST_IDLE;
            baseline_q <= '0;
            hold_len_q <= '0;
            hcnt_q     <= '0;
            tcnt_q     <= '0;
            sel_q      <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baseline_q <= baseline_d;
            hold_len_q <= hold_len_d;
            hcnt_q     <= hcnt_d;
            tcnt_q     <= tcnt_d;
            sel_q      <= sel_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    x_sat_cnt #(
        .W(CNT_W)
    ) u_count (
        .clk   (i_clk),
        .rst_n (i_nrst),
        .en    (count_en),
        .count (o_count)
    );

    assign o_sel     = sel_q;
    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_busy    = busy_q;
    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_x_trigger_dual_ctrl.sv
// Directed bench for x_trigger_dual_ctrl with a short timeout and a 3-bit
// capture counter so both expiry and saturation are reachable quickly.
module tb_x_trigger_dual_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] data_in;
    logic        arm;
    logic        abort_req;
    logic [15:0] holdoff;
    logic        ready;
    logic        sel;
    logic [31:0] data_out;
    logic        valid;
    logic        busy;
    logic        timeout;
    logic [2:0]  count;

    int vectors;
    int miscompares;

    x_trigger_dual_ctrl #(
        .DATA_W  (32),
        .HOLD_W  (16),
        .TIMEOUT (8),
        .CNT_W   (3)
    ) dut (
        .i_clk     (clk),
        .i_nrst    (rst_n),
        .i_data    (data_in),
        .i_arm     (arm),
        .i_abort   (abort_req),
        .i_holdoff (holdoff),
        .i_ready   (ready),
        .o_sel     (sel),
        .o_data    (data_out),
        .o_valid   (valid),
        .o_busy    (busy),
        .o_timeout (timeout),
        .o_count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b1;
        data_in     = 32'h0;
        arm         = 1'b0;
        abort_req   = 1'b0;
        holdoff     = 16'd0;
        ready       = 1'b1;

        #1 rst_n = 1'b0;
        #2;
        check_output("rst_valid", 32'(valid), 32'd0);
        check_output("rst_sel", 32'(sel), 32'd0);
        check_output("rst_count", 32'(count), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_timeout", 32'(timeout), 32'd0);
        check_output("rst_data", data_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic capture: change three cycles after arming, one-cycle latency.
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check_output("t1_busy", 32'(busy), 32'd1);
        tick();
        tick();
        check_output("t1_no_early_valid", 32'(valid), 32'd0);
        data_in = 32'hCCCC_CCCC;
        tick();
        check_output("t1_valid", 32'(valid), 32'd1);
        check_output("t1_data", data_out, 32'hCCCC_CCCC);
        check_output("t1_sel_before", 32'(sel), 32'd0);
        tick();
        check_output("t1_valid_drop", 32'(valid), 32'd0);
        check_output("t1_sel", 32'(sel), 32'd1);
        check_output("t1_count", 32'(count), 32'd1);
        check_output("t1_idle", 32'(busy), 32'd0);

        // Backpressure for five cycles, then a four-cycle hold-off.
        arm     = 1'b1;
        holdoff = 16'd4;
        ready   = 1'b0;
        tick();
        arm     = 1'b0;
        holdoff = 16'd0;
        data_in = 32'h1234_5678;
        tick();
        check_output("t2_valid", 32'(valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            data_in = 32'hDEAD_0000 + 32'(i);
            tick();
            check_output("t2_hold_valid", 32'(valid), 32'd1);
            check_output("t2_hold_data", data_out, 32'h1234_5678);
        end
        ready = 1'b1;
        tick();
        check_output("t2_accept_valid", 32'(valid), 32'd0);
        check_output("t2_sel", 32'(sel), 32'd0);
        check_output("t2_count", 32'(count), 32'd2);
        check_output("t2_busy0", 32'(busy), 32'd1);
        arm = 1'b1;
        tick();
        check_output("t2_busy1", 32'(busy), 32'd1);
        tick();
        arm = 1'b0;
        check_output("t2_busy2", 32'(busy), 32'd1);
        tick();
        check_output("t2_busy3", 32'(busy), 32'd1);
        tick();
        check_output("t2_busy_drop", 32'(busy), 32'd0);
        tick();
        check_output("t2_arm_not_queued", 32'(busy), 32'd0);

        // Timeout: constant input for eight ARMED cycles.
        data_in = 32'h0000_FFFF;
        arm     = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            check_output("t3_no_timeout_yet", 32'(timeout), 32'd0);
        end
        tick();
        check_output("t3_timeout", 32'(timeout), 32'd1);
        check_output("t3_busy", 32'(busy), 32'd0);
        check_output("t3_sel", 32'(sel), 32'd0);
        check_output("t3_count", 32'(count), 32'd2);
        tick();
        check_output("t3_pulse_end", 32'(timeout), 32'd0);

        // Trigger on the expiry cycle beats the timeout.
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        data_in = 32'h0000_FFFE;
        tick();
        check_output("t3b_valid", 32'(valid), 32'd1);
        check_output("t3b_no_timeout", 32'(timeout), 32'd0);
        check_output("t3b_data", data_out, 32'h0000_FFFE);
        tick();
        check_output("t3b_sel", 32'(sel), 32'd1);
        check_output("t3b_count", 32'(count), 32'd3);

        // Abort together with an accepted handshake.
        data_in = 32'h0;
        holdoff = 16'd4;
        arm     = 1'b1;
        tick();
        arm     = 1'b0;
        holdoff = 16'd0;
        data_in = 32'h1;
        tick();
        check_output("t5_valid", 32'(valid), 32'd1);
        abort_req = 1'b1;
        tick();
        abort_req = 1'b0;
        check_output("t5_valid_drop", 32'(valid), 32'd0);
        check_output("t5_busy", 32'(busy), 32'd0);
        check_output("t5_sel", 32'(sel), 32'd1);
        check_output("t5_count", 32'(count), 32'd3);

        // Four back-to-back captures ping-pong the path select.
        for (int k = 0; k < 4; k++) begin
            data_in = 32'hA5A5_0000 + 32'(k);
            arm     = 1'b1;
            tick();
            arm     = 1'b0;
            data_in = ~(32'hA5A5_0000 + 32'(k));
            tick();
            check_output("t4_valid", 32'(valid), 32'd1);
            tick();
            check_output("t4_sel", 32'(sel), 32'(k[0]));
            check_output("t4_count", 32'(count), 32'(4 + k));
        end

        // Saturation at 7; arm on the cycle IDLE is re-entered is dropped.
        data_in = 32'h5555_5555;
        arm     = 1'b1;
        tick();
        arm     = 1'b0;
        data_in = 32'hAAAA_AAAA;
        tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check_output("t6_sat_count", 32'(count), 32'd7);
        check_output("t6_sel", 32'(sel), 32'd0);
        tick();
        check_output("t6_reentry_arm_ignored", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a stalled capture.
        ready   = 1'b0;
        data_in = 32'h0;
        arm     = 1'b1;
        tick();
        arm     = 1'b0;
        data_in = 32'h0F0F_0F0F;
        tick();
        check_output("t7_valid", 32'(valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_output("t7_rst_valid", 32'(valid), 32'd0);
        check_output("t7_rst_data", data_out, 32'h0);
        check_output("t7_rst_busy", 32'(busy), 32'd0);
        check_output("t7_rst_count", 32'(count), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        ready   = 1'b1;
        data_in = 32'h0;
        arm     = 1'b1;
        tick();
        arm = 1'b0;
        check_output("t7_rearm_busy", 32'(busy), 32'd1);
        data_in = 32'h0000_0042;
        tick();
        check_output("t7_rearm_data", data_out, 32'h0000_0042);
        tick();
        check_output("t7_rearm_count", 32'(count), 32'd1);
        check_output("t7_rearm_sel", 32'(sel), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
